// File: rtl/nrisc_multicycle_sequencer.sv
// nRisc multi-cycle control sequencer.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
module nrisc_multicycle_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             mem_ready,
  input  logic [7:0]       mem_rdata,
  input  logic             cmp_eq,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_load,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             alu_src,
  output logic             alu_op,
  output logic             reg_src,
  output logic             cmp_en,
  output logic [7:0]       ir,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;

  logic [3:0] opc;
  logic is_add, is_addi, is_sub, is_jmp, is_mov;
  logic is_beq, is_ld, is_st, is_nop, is_ill;
  logic is_alu, jump;
  logic retire;

  assign opc     = ir_q[7:4];
  assign is_add  = (opc == 4'd0);
  assign is_addi = (opc == 4'd1);
  assign is_sub  = (opc == 4'd2);
  assign is_jmp  = (opc == 4'd3);
  assign is_mov  = (opc == 4'd4);
  assign is_beq  = (opc == 4'd5);
  assign is_ld   = (opc == 4'd6);
  assign is_st   = (opc == 4'd7);
  assign is_nop  = (opc == 4'd8);
  assign is_ill  = (opc >= 4'd9);
  assign is_alu  = is_add | is_addi | is_sub | is_mov;
  assign jump    = is_jmp | (is_beq & cmp_eq);

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    unique case (state_q)
      S_IDLE:
        if (run) state_d = S_FETCH;
      S_FETCH:
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      S_DECODE: begin
        if (is_ill) illegal_d = 1'b1;
        if (is_nop | is_ill) retire = 1'b1;
        else state_d = S_EXEC;
      end
      S_EXEC:
        if (is_alu) state_d = S_WB;
        else if (is_ld | is_st) state_d = S_MEM;
        else retire = 1'b1;
      S_MEM:
        if (mem_ready) begin
          if (is_st) retire = 1'b1;
          else state_d = S_WB;
        end
      S_WB:
        retire = 1'b1;
      default:
        state_d = S_IDLE;
    endcase
    if (retire) begin
      retired_d = retired_q + CNT_W'(1);
      state_d   = run ? S_FETCH : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ir_q      <= 8'h00;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    mem_req      = (state_q == S_FETCH) | (state_q == S_MEM);
    mem_addr_sel = (state_q == S_MEM);
    mem_we       = (state_q == S_MEM) & is_st;
    ir_load      = (state_q == S_FETCH) & mem_ready;
    pc_src       = (state_q == S_EXEC) & jump;
    pc_write     = ir_load | pc_src;
    reg_write    = (state_q == S_WB);
    reg_src      = (state_q == S_WB) & is_ld;
    alu_src      = (state_q == S_EXEC) & (is_addi | is_ld | is_st);
    alu_op       = (state_q == S_EXEC) & is_sub;
    cmp_en       = (state_q == S_EXEC) & is_beq;
  end

  // Illegal shows during the DECODE cycle itself, then via the sticky flop.
  assign illegal = illegal_q | ((state_q == S_DECODE) & is_ill);
  assign ir      = ir_q;
  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_nrisc_multicycle_sequencer.sv
// Directed bench for nrisc_multicycle_sequencer.
// Small counter width so the wrap case is reachable.
module tb_nrisc_multicycle_sequencer;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, run, mem_ready, cmp_eq;
  logic [7:0]    mem_rdata;
  logic          mem_req, mem_we, mem_addr_sel, ir_load;
  logic          pc_write, pc_src, reg_write, alu_src;
  logic          alu_op, reg_src, cmp_en, illegal;
  logic [7:0]    ir;
  logic [2:0]    state;
  logic [CW-1:0] retired;
  logic [10:0]   strobes;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_ret = '0;

  nrisc_multicycle_sequencer #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .run(run),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .cmp_eq(cmp_eq), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_load(ir_load),
    .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .alu_src(alu_src),
    .alu_op(alu_op), .reg_src(reg_src), .cmp_en(cmp_en),
    .ir(ir), .state(state), .retired(retired),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign strobes = {mem_req, mem_we, mem_addr_sel, ir_load,
                    pc_write, pc_src, reg_write, alu_src,
                    alu_op, reg_src, cmp_en};

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    reset = 1; run = 0; mem_ready = 0; cmp_eq = 0;
    mem_rdata = 8'h00;
    tick(); tick();
    reset = 0;
    settle();
    checks++;
    if (state !== 3'd0 || strobes !== 11'h000 || retired !== 4'd0 ||
        illegal !== 1'b0 || ir !== 8'h00) begin
      errors++;
      $display("FAIL reset st=%0d strb=%h ret=%0d ill=%b ir=%h exp 0",
               state, strobes, retired, illegal, ir);
    end
    mem_ready = 1;
    tick();
    checks++;
    if (state !== 3'd0 || strobes !== 11'h000) begin
      errors++;
      $display("FAIL idle_hold st=%0d strb=%h exp 0/000",
               state, strobes);
    end
  endtask

  task automatic test_add();
    logic [2:0]  exp_st [5];
    logic [10:0] exp_sb [5];
    exp_st = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    exp_sb = '{11'h4C0, 11'h000, 11'h000, 11'h010, 11'h4C0};
    run = 1; mem_ready = 1; mem_rdata = 8'h00;
    tick();
    for (int i = 0; i < 5; i++) begin
      settle();
      checks++;
      if (state !== exp_st[i] || strobes !== exp_sb[i]) begin
        errors++;
        $display("FAIL add_c%0d st=%0d strb=%h exp %0d/%h",
                 i, state, strobes, exp_st[i], exp_sb[i]);
      end
      if (i < 4) tick();
    end
    exp_ret = exp_ret + 1'b1;
    checks++;
    if (retired !== exp_ret) begin
      errors++;
      $display("FAIL add_retired got %0d exp %0d", retired, exp_ret);
    end
  endtask

  task automatic test_load_wait();
    mem_ready = 1; mem_rdata = 8'h60;
    tick();
    checks++;
    if (state !== 3'd2 || ir !== 8'h60) begin
      errors++;
      $display("FAIL ld_decode st=%0d ir=%h exp 2/60", state, ir);
    end
    tick();
    mem_ready = 0;
    settle();
    checks++;
    if (state !== 3'd3 || strobes !== 11'h008) begin
      errors++;
      $display("FAIL ld_exec st=%0d strb=%h exp 3/008", state, strobes);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) mem_ready = 1;
      settle();
      checks++;
      if (state !== 3'd4 || strobes !== 11'h500) begin
        errors++;
        $display("FAIL ld_mem%0d st=%0d strb=%h exp 4/500",
                 i, state, strobes);
      end
    end
    tick();
    checks++;
    if (state !== 3'd5 || strobes !== 11'h012) begin
      errors++;
      $display("FAIL ld_wb st=%0d strb=%h exp 5/012", state, strobes);
    end
    tick();
    exp_ret = exp_ret + 1'b1;
    checks++;
    if (state !== 3'd1 || retired !== exp_ret) begin
      errors++;
      $display("FAIL ld_done st=%0d ret=%0d exp 1/%0d",
               state, retired, exp_ret);
    end
  endtask

  task automatic test_beq(input logic eq);
    logic [10:0] exp_sb;
    exp_sb = eq ? 11'h061 : 11'h001;
    mem_ready = 1; mem_rdata = 8'h50;
    tick(); tick();
    cmp_eq = eq;
    settle();
    checks++;
    if (state !== 3'd3 || strobes !== exp_sb) begin
      errors++;
      $display("FAIL beq%0b_exec st=%0d strb=%h exp 3/%h",
               eq, state, strobes, exp_sb);
    end
    tick();
    cmp_eq = 0;
    exp_ret = exp_ret + 1'b1;
    checks++;
    if (state !== 3'd1 || retired !== exp_ret) begin
      errors++;
      $display("FAIL beq%0b_done st=%0d ret=%0d exp 1/%0d",
               eq, state, retired, exp_ret);
    end
  endtask

  task automatic test_illegal();
    mem_ready = 1; mem_rdata = 8'hF0;
    settle();
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("FAIL ill_pre got %b exp 0", illegal);
    end
    tick();
    checks++;
    if (state !== 3'd2 || illegal !== 1'b1 || strobes !== 11'h000) begin
      errors++;
      $display("FAIL ill_decode st=%0d ill=%b strb=%h exp 2/1/000",
               state, illegal, strobes);
    end
    mem_rdata = 8'h80;
    tick();
    exp_ret = exp_ret + 1'b1;
    checks++;
    if (state !== 3'd1 || illegal !== 1'b1 || retired !== exp_ret) begin
      errors++;
      $display("FAIL ill_retire st=%0d ill=%b ret=%0d exp 1/1/%0d",
               state, illegal, retired, exp_ret);
    end
    tick(); tick();
    exp_ret = exp_ret + 1'b1;
    checks++;
    if (state !== 3'd1 || illegal !== 1'b1 || retired !== exp_ret) begin
      errors++;
      $display("FAIL ill_sticky st=%0d ill=%b ret=%0d exp 1/1/%0d",
               state, illegal, retired, exp_ret);
    end
  endtask

  task automatic test_reset_mid_store();
    mem_ready = 1; mem_rdata = 8'h70;
    tick(); tick();
    mem_ready = 0;
    tick();
    checks++;
    if (state !== 3'd4 || strobes !== 11'h700) begin
      errors++;
      $display("FAIL st_mem st=%0d strb=%h exp 4/700", state, strobes);
    end
    reset = 1;
    tick();
    reset = 0;
    settle();
    exp_ret = '0;
    checks++;
    if (state !== 3'd0 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
        retired !== 4'd0 || illegal !== 1'b0 || ir !== 8'h00) begin
      errors++;
      $display("FAIL st_reset st=%0d req=%b we=%b ret=%0d ill=%b ir=%h exp 0",
               state, mem_req, mem_we, retired, illegal, ir);
    end
    mem_ready = 1;
    tick();
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL st_restart st=%0d exp 1", state);
    end
  endtask

  task automatic test_run_drop_wrap();
    mem_ready = 1; mem_rdata = 8'h80;
    for (int i = 0; i < 15; i++) begin
      tick(); tick();
    end
    checks++;
    if (retired !== 4'hF || state !== 3'd1) begin
      errors++;
      $display("FAIL nop_fill ret=%0d st=%0d exp 15/1", retired, state);
    end
    mem_rdata = 8'h20;
    tick(); tick();
    checks++;
    if (state !== 3'd3 || strobes !== 11'h004) begin
      errors++;
      $display("FAIL sub_exec st=%0d strb=%h exp 3/004", state, strobes);
    end
    run = 0;
    tick();
    checks++;
    if (state !== 3'd5 || strobes !== 11'h010) begin
      errors++;
      $display("FAIL sub_wb st=%0d strb=%h exp 5/010", state, strobes);
    end
    tick();
    checks++;
    if (state !== 3'd0 || strobes !== 11'h000 || retired !== 4'd0) begin
      errors++;
      $display("FAIL sub_park st=%0d strb=%h ret=%0d exp 0/000/0",
               state, strobes, retired);
    end
    tick(); tick();
    checks++;
    if (state !== 3'd0 || retired !== 4'd0) begin
      errors++;
      $display("FAIL idle_stay st=%0d ret=%0d exp 0/0", state, retired);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_beq(1'b1);
    test_beq(1'b0);
    test_illegal();
    test_reset_mid_store();
    test_run_drop_wrap();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/nrisc_multicycle_sequencer.md
# nrisc_multicycle_sequencer

Multi-cycle FSM that sequences the nRisc 8-bit datapath. It fetches an instruction byte over a shared single-port memory with a req/ready handshake, then steps it through decode, execute, memory and writeback. In each state it drives the datapath control strobes (register write, ALU source/op, jump, register source, comparator, memory read/write). It sits between instruction/data memory and the register file/ALU, and provides per-state control in place of a single-cycle decoder.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- run  in  1  enable; sampled in IDLE and at instruction retirement
- mem_ready  in  1  memory completes the current request this cycle
- mem_rdata  in  8  memory read data (instruction byte during FETCH)
- cmp_eq  in  1  datapath comparator result, valid in EXEC of BEQ
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write request (STORE in MEM)
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_load  out  1  latch mem_rdata into IR
- pc_write  out  1  PC update strobe
- pc_src  out  1  0 = PC+1, 1 = jump target
- reg_write  out  1  register file write
- alu_src  out  1  0 = register, 1 = immediate
- alu_op  out  1  0 = add, 1 = subtract
- reg_src  out  1  writeback source: 0 = ALU, 1 = memory
- cmp_en  out  1  comparator enable
- ir  out  8  current instruction register
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5
- retired  out  CNT_W  retired-instruction count
- illegal  out  1  sticky: an undefined opcode was decoded

## Operation
- Opcode = ir[7:4]: 0 ADD, 1 ADDI, 2 SUB, 3 JMP, 4 MOV, 5 BEQ, 6 LOAD, 7 STORE, 8 NOP. Opcodes 9–15 are illegal: set `illegal`, then execute as NOP.
- IDLE: all strobes 0. Go to FETCH when run=1.
- FETCH: mem_req=1, mem_addr_sel=0.
  - mem_ready=0: stay in FETCH.
  - mem_ready=1: ir_load=1 and pc_write=1 (pc_src=0) combinationally in the same cycle; IR captures mem_rdata; go to DECODE.
- DECODE: no strobes. NOP/illegal retire here; all other opcodes go to EXEC.
- EXEC:
  - ADD/SUB/ADDI/MOV: alu_op=1 for SUB only; alu_src=1 for ADDI; go to WB.
  - JMP: pc_write=1, pc_src=1; retire.
  - BEQ: cmp_en=1; if cmp_eq=1 then pc_write=1, pc_src=1; retire.
  - LOAD/STORE: alu_src=1 (address calculation); go to MEM.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for STORE.
  - Stay in MEM until mem_ready=1.
  - On mem_ready: STORE retires; LOAD goes to WB.
- WB: reg_write=1; reg_src=1 for LOAD, 0 otherwise; retire.
- Retirement: `retired` increments by 1 (wraps from all-ones to 0). Next state is FETCH if run=1, else IDLE.
- Control outputs are Moore decodes of state and IR. The exceptions are ir_load, pc_write in FETCH, and the MEM exit, which are also gated by mem_ready.
- Reset (any state, including mid-handshake): next edge forces IDLE, IR=0, retired=0, illegal=0. All outputs read 0 after reset.

## Timing
- Zero-wait memory cycle counts:
  - ADD/SUB/ADDI/MOV: 4 cycles (FETCH, DECODE, EXEC, WB)
  - LOAD: 5 cycles
  - STORE: 4 cycles
  - JMP/BEQ: 3 cycles
  - NOP/illegal: 2 cycles
- Each cycle with mem_ready=0 in FETCH or MEM adds exactly one cycle.
- mem_req stays high and mem_addr_sel/mem_we stay stable while waiting. mem_req drops in the cycle after the handshake.
- One memory transfer per mem_req & mem_ready cycle. mem_ready while mem_req=0 is ignored.
- pc_write asserts at most twice per instruction (FETCH increment, EXEC jump). The jump write follows the increment, so the jump target wins.
- `run` going low mid-instruction does not abort. The instruction completes, then the FSM parks in IDLE.
- `illegal` sets on the DECODE cycle and stays set until reset.

## Test plan
- Reset, run=1, mem_ready=1, mem_rdata=0x00 (ADD) → states 1,2,3,5,1; reg_write=1 only in WB; retired=1 after 4 cycles.
- LOAD 0x60 with mem_ready low for 2 cycles in MEM → mem_req held 3 cycles with mem_addr_sel=1; WB has reg_src=1; total 7 cycles.
- BEQ 0x50 with cmp_eq=1, then again with cmp_eq=0 → EXEC pc_write=1/pc_src=1 in the first case, pc_write=0 in the second; 3 cycles each.
- Opcode 0xF0 → illegal=1 from DECODE onward and held; instruction retires in 2 cycles; retired increments.
- Reset asserted during MEM of a STORE → next cycle state=0, mem_req=0, mem_we=0, retired=0, illegal=0.
- run dropped during EXEC of SUB 0x20 → WB completes, then state=IDLE with all strobes 0. Preload retired to all-ones: it wraps to 0 on this retirement.
